// File: rtl/powerup_arbiter_if.sv
// MMIO window bus between the processor dmem port and powerup_arbiter.
//   mmio_addr  : processor word address (17b)
//   mmio_wdata : write data
//   mmio_wren  : write strobe
//   mmio_hit   : address falls inside the powerup window (combinational)
//   mmio_rdata : registered read data, valid the edge after mmio_addr
// master = processor side, slave = powerup_arbiter.
interface powerup_arbiter_if;
  logic [16:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_wren;
  logic        mmio_hit;
  logic [31:0] mmio_rdata;

  modport master (output mmio_addr, output mmio_wdata, output mmio_wren,
                  input  mmio_hit,  input  mmio_rdata);
  modport slave  (input  mmio_addr, input  mmio_wdata, input  mmio_wren,
                  output mmio_hit,  output mmio_rdata);
endinterface

// File: rtl/powerup_arbiter.sv
// powerup_arbiter: tracks N_POWERUPS on-field powerups against N_PLAYERS
// player boxes, grants timed effects on pickup and exposes state over MMIO.
// All state changes on the falling clock edge to match the processor skeleton.
//
// Optional feature macro: POWERUP_RESPAWN_EN
//   defined   : HELD -> RESPAWN -> FIELD (powerup returns home after RESPAWN_TICKS)
//   undefined : HELD -> DEAD; only a status re-arm write or reset restores it
//
// Ports (powerup_arbiter):
//   i_clock          clock, state updates on negedge
//   i_reset          async active-low reset
//   i_player_x/y     flattened player left/top edges
//   mmio             powerup_arbiter_if.slave (addr/wdata/wren in, hit/rdata out)
//   o_pu_x/o_pu_y    flattened draw positions, all-ones when off-field
//   o_pu_active      per-powerup drawn/collectable
//   o_player_effect  bit [p*N_POWERUPS+i] = player p holds effect i
//
// MMIO map (word addresses, window = BASE_ADDR .. BASE_ADDR+39):
//   +4i+0 x home (RW), +4i+1 y home (RW),
//   +4i+2 status R {owner[7:5],state[1:0]} / W bit0 = re-arm,
//   +4i+3 remaining ticks (R), +32+p player p effect mask (R).

// One powerup: FIELD/HELD/RESPAWN/DEAD FSM, its tick counter, owner and home.
module powerup_slot #(
  parameter int N_PLAYERS      = 2,
  parameter int COORD_W        = 10,
  parameter int DURATION_TICKS = 8,
`ifdef POWERUP_RESPAWN_EN
  parameter int RESPAWN_TICKS  = 5,
`endif
  parameter logic [COORD_W-1:0] HX = '0,
  parameter logic [COORD_W-1:0] HY = '0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic [N_PLAYERS-1:0] i_ov,
  input  logic                 i_wr_x,
  input  logic                 i_wr_y,
  input  logic                 i_rearm,
  input  logic [COORD_W-1:0]   i_wdata,
  output logic [1:0]           o_state,
  output logic [2:0]           o_owner,
  output logic [COORD_W-1:0]   o_home_x,
  output logic [COORD_W-1:0]   o_home_y,
  output logic [7:0]           o_remain
);
  typedef enum logic [1:0] {S_FIELD = 2'd0, S_HELD = 2'd1, S_RESPAWN = 2'd2, S_DEAD = 2'd3} state_t;

  state_t             r_state, w_state_n;
  logic [7:0]         r_tcnt,  w_tcnt_n;
  logic [2:0]         r_owner, w_owner_n, w_win;
  logic [COORD_W-1:0] r_home_x, r_home_y;
  logic               w_pick;

  assign w_pick = (r_state == S_FIELD) && (|i_ov);

  // Lowest overlapping player index wins a simultaneous grab.
  always_comb begin
    w_win = '0;
    for (int p = N_PLAYERS-1; p >= 0; p--)
      if (i_ov[p]) w_win = 3'(p);
  end

  always_comb begin
    w_state_n = r_state;
    w_tcnt_n  = r_tcnt;
    w_owner_n = r_owner;
    case (r_state)
      S_FIELD: if (w_pick) begin
        w_state_n = S_HELD;
        w_tcnt_n  = '0;
        w_owner_n = w_win;
      end
      // Expiry compares the pre-increment count on the tick edge.
      S_HELD: if (i_tick) begin
        if (r_tcnt == 8'(DURATION_TICKS-1)) begin
`ifdef POWERUP_RESPAWN_EN
          w_state_n = S_RESPAWN;
`else
          w_state_n = S_DEAD;
`endif
          w_tcnt_n  = '0;
        end else begin
          w_tcnt_n  = r_tcnt + 8'd1;
        end
      end
`ifdef POWERUP_RESPAWN_EN
      S_RESPAWN: if (i_tick) begin
        if (r_tcnt == 8'(RESPAWN_TICKS-1)) begin
          w_state_n = S_FIELD;
          w_tcnt_n  = '0;
        end else begin
          w_tcnt_n  = r_tcnt + 8'd1;
        end
      end
`endif
      default: ;
    endcase
    // Re-arm from any state, but a same-edge pickup takes priority.
    if (i_rearm && !w_pick) begin
      w_state_n = S_FIELD;
      w_tcnt_n  = '0;
    end
  end

  always_ff @(negedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_FIELD;
      r_tcnt   <= '0;
      r_owner  <= '0;
      r_home_x <= HX;
      r_home_y <= HY;
    end else begin
      r_state <= w_state_n;
      r_tcnt  <= w_tcnt_n;
      r_owner <= w_owner_n;
      if (i_wr_x) r_home_x <= i_wdata;
      if (i_wr_y) r_home_y <= i_wdata;
    end
  end

  always_comb begin
    o_remain = '0;
    if (r_state == S_HELD) o_remain = 8'(DURATION_TICKS) - r_tcnt;
`ifdef POWERUP_RESPAWN_EN
    if (r_state == S_RESPAWN) o_remain = 8'(RESPAWN_TICKS) - r_tcnt;
`endif
  end

  assign o_state  = r_state;
  assign o_owner  = r_owner;
  assign o_home_x = r_home_x;
  assign o_home_y = r_home_y;
endmodule

module powerup_arbiter #(
  parameter int N_PLAYERS      = 2,
  parameter int N_POWERUPS     = 2,
  parameter int COORD_W        = 10,
  parameter int SIZE           = 24,
  parameter int TICK_DIV       = 100000000,
  parameter int DURATION_TICKS = 8,
  parameter int RESPAWN_TICKS  = 5,
  parameter logic [N_POWERUPS*COORD_W-1:0] HOME_X = {10'd400, 10'd300},
  parameter logic [N_POWERUPS*COORD_W-1:0] HOME_Y = {10'd400, 10'd300},
  parameter logic [16:0] BASE_ADDR = 17'd4400
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [N_PLAYERS*COORD_W-1:0]    i_player_x,
  input  logic [N_PLAYERS*COORD_W-1:0]    i_player_y,
  powerup_arbiter_if.slave                mmio,
  output logic [N_POWERUPS*COORD_W-1:0]   o_pu_x,
  output logic [N_POWERUPS*COORD_W-1:0]   o_pu_y,
  output logic [N_POWERUPS-1:0]           o_pu_active,
  output logic [N_PLAYERS*N_POWERUPS-1:0] o_player_effect
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [COORD_W:0] W_SZ = (COORD_W+1)'(SIZE);

  logic [PW-1:0] r_pcnt;
  logic          w_tick;

  logic [N_POWERUPS-1:0][N_PLAYERS-1:0] w_ov;
  logic [N_POWERUPS-1:0][1:0]           w_state;
  logic [N_POWERUPS-1:0][2:0]           w_owner;
  logic [N_POWERUPS-1:0][COORD_W-1:0]   w_home_x, w_home_y;
  logic [N_POWERUPS-1:0][7:0]           w_remain;
  logic [N_POWERUPS-1:0]                w_sel;
  logic [N_PLAYERS-1:0][N_POWERUPS-1:0] w_mask;

  logic        w_hit;
  logic [5:0]  w_off;
  logic [31:0] w_rd, r_rdata;

  // Shared prescaler; tick is high during the cycle the counter wraps.
  assign w_tick = (r_pcnt == PW'(TICK_DIV-1));
  always_ff @(negedge i_clock or negedge i_reset) begin
    if (!i_reset)    r_pcnt <= '0;
    else if (w_tick) r_pcnt <= '0;
    else             r_pcnt <= r_pcnt + 1'b1;
  end

  assign w_hit = (mmio.mmio_addr >= BASE_ADDR) && (mmio.mmio_addr < BASE_ADDR + 17'd40);
  assign w_off = 6'(mmio.mmio_addr - BASE_ADDR);

  for (genvar i = 0; i < N_POWERUPS; i++) begin : g_pu
    // Overlap in COORD_W+1 bits so px+SIZE never wraps; edges are inclusive.
    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_ov
      logic [COORD_W:0] w_px, w_py, w_ux, w_uy;
      assign w_px = {1'b0, i_player_x[p*COORD_W +: COORD_W]};
      assign w_py = {1'b0, i_player_y[p*COORD_W +: COORD_W]};
      assign w_ux = {1'b0, w_home_x[i]};
      assign w_uy = {1'b0, w_home_y[i]};
      assign w_ov[i][p] = (w_px + W_SZ >= w_ux) && (w_px <= w_ux + W_SZ) &&
                          (w_py + W_SZ >= w_uy) && (w_py <= w_uy + W_SZ);
    end

    assign w_sel[i] = mmio.mmio_wren && w_hit && !w_off[5] && (w_off[4:2] == 3'(i));

    powerup_slot #(
      .N_PLAYERS     (N_PLAYERS),
      .COORD_W       (COORD_W),
      .DURATION_TICKS(DURATION_TICKS),
`ifdef POWERUP_RESPAWN_EN
      .RESPAWN_TICKS (RESPAWN_TICKS),
`endif
      .HX            (HOME_X[i*COORD_W +: COORD_W]),
      .HY            (HOME_Y[i*COORD_W +: COORD_W])
    ) u_slot (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_tick  (w_tick),
      .i_ov    (w_ov[i]),
      .i_wr_x  (w_sel[i] && (w_off[1:0] == 2'd0)),
      .i_wr_y  (w_sel[i] && (w_off[1:0] == 2'd1)),
      .i_rearm (w_sel[i] && (w_off[1:0] == 2'd2) && mmio.mmio_wdata[0]),
      .i_wdata (mmio.mmio_wdata[COORD_W-1:0]),
      .o_state (w_state[i]),
      .o_owner (w_owner[i]),
      .o_home_x(w_home_x[i]),
      .o_home_y(w_home_y[i]),
      .o_remain(w_remain[i])
    );

    // Draw position follows home while on-field, so home writes show at once.
    assign o_pu_active[i]             = (w_state[i] == 2'd0);
    assign o_pu_x[i*COORD_W +: COORD_W] = o_pu_active[i] ? w_home_x[i] : '1;
    assign o_pu_y[i*COORD_W +: COORD_W] = o_pu_active[i] ? w_home_y[i] : '1;

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_eff
      assign w_mask[p][i] = (w_state[i] == 2'd1) && (w_owner[i] == 3'(p));
      assign o_player_effect[p*N_POWERUPS+i] = w_mask[p][i];
    end
  end

  // Read mux; unmapped words inside the window read as zero.
  always_comb begin
    w_rd = '0;
    if (!w_off[5]) begin
      for (int i = 0; i < N_POWERUPS; i++)
        if (w_off[4:2] == 3'(i))
          case (w_off[1:0])
            2'd0:    w_rd = 32'(w_home_x[i]);
            2'd1:    w_rd = 32'(w_home_y[i]);
            2'd2:    w_rd = {24'b0, w_owner[i], 3'b0, w_state[i]};
            default: w_rd = {24'b0, w_remain[i]};
          endcase
    end else if (w_off[4:3] == 2'b00) begin
      for (int p = 0; p < N_PLAYERS; p++)
        if (w_off[2:0] == 3'(p)) w_rd = 32'(w_mask[p]);
    end
  end

  always_ff @(negedge i_clock or negedge i_reset) begin
    if (!i_reset) r_rdata <= '0;
    else          r_rdata <= w_hit ? w_rd : 32'd0;
  end

  assign mmio.mmio_hit   = w_hit;
  assign mmio.mmio_rdata = r_rdata;
endmodule
